// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode encodings.
package usr_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

endpackage

// File: rtl/dff_ar_cell.sv
// Single storage bit with true and complement outputs and async active-low
// reset to a per-instance value.
module dff_ar_cell (
    input  logic Clk,
    input  logic Rst_n,
    input  logic RstVal,
    input  logic D,
    output logic Q,
    output logic Qn
);

    logic q_d, q_q;
    logic qn_d, qn_q;

    always_comb begin
        q_d  = D;
        qn_d = ~D;
    end

    // Complement is its own flop so Qn is registered and tracks Q exactly.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            q_q  <= RstVal;
            qn_q <= ~RstVal;
        end else begin
            q_q  <= q_d;
            qn_q <= qn_d;
        end
    end

    assign Q  = q_q;
    assign Qn = qn_q;

endmodule

// File: rtl/universal_shift_register.sv
// WIDTH-bit hold/shift-right/shift-left/load register with a saturating shift
// counter driving Full. Define USR_ROTATE_EN to add the Rot (rotate) input.
module universal_shift_register
    import usr_pkg::*;
#(
    parameter int unsigned        WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             En,
    input  logic [1:0]       Mode,
    input  logic [WIDTH-1:0] D,
    input  logic             SinL,
    input  logic             SinR,
`ifdef USR_ROTATE_EN
    input  logic             Rot,
`endif
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic             SoutR,
    output logic             SoutL,
    output logic             Full
);

    localparam int unsigned      CNT_W   = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] shr_vec;
    logic [WIDTH-1:0] shl_vec;
    logic             ser_msb;
    logic             ser_lsb;
    logic [CNT_W-1:0] count_d, count_q;
    logic             full_d, full_q;

    // Serial bits entering at each end; rotation recirculates the leaving bit.
`ifdef USR_ROTATE_EN
    assign ser_msb = Rot ? Q[0]       : SinL;
    assign ser_lsb = Rot ? Q[WIDTH-1] : SinR;
`else
    assign ser_msb = SinL;
    assign ser_lsb = SinR;
`endif

    assign shr_vec = {ser_msb, Q[WIDTH-1:1]};
    assign shl_vec = {Q[WIDTH-2:0], ser_lsb};

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        always_comb begin
            q_d[i] = Q[i];
            if (En) begin
                case (Mode)
                    MODE_SHR:  q_d[i] = shr_vec[i];
                    MODE_SHL:  q_d[i] = shl_vec[i];
                    MODE_LOAD: q_d[i] = D[i];
                    default:   q_d[i] = Q[i];
                endcase
            end
        end

        dff_ar_cell u_cell (
            .Clk    (Clk),
            .Rst_n  (Rst_n),
            .RstVal (RESET_VAL[i]),
            .D      (q_d[i]),
            .Q      (Q[i]),
            .Qn     (Qn[i])
        );
    end

    // Shift counter saturates at WIDTH; Full is decoded from its next value.
    always_comb begin
        count_d = count_q;
        if (En) begin
            case (Mode)
                MODE_SHR, MODE_SHL: begin
                    if (count_q != CNT_MAX) begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
                MODE_LOAD: count_d = '0;
                default:   count_d = count_q;
            endcase
        end
        full_d = (count_d == CNT_MAX);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

    assign SoutR = Q[0];
    assign SoutL = Q[WIDTH-1];
    assign Full  = full_q;

endmodule
